idct4x4_stream: RTL

- 2-D 4x4 inverse integer transform. It is the decoder counterpart of the forward DCT4 butterfly pair used in the watermark embed path.
- Accepts 4x4 blocks of signed coefficients, which may have been modified by the watermark stage, one coefficient column per beat. Emits reconstructed 8-bit pixel rows.
- Sits after watermark insertion and before pixel write-back.
- Ping-pong transpose buffer sustains one beat per clock on both sides.

---
 rtl/idct4x4_stream_pkg.sv | 19 +
 rtl/idct4_1d.sv | 27 ++
 rtl/idct4x4_stream.sv | 116 +++++++++++
 3 files changed

// File: rtl/idct4x4_stream_pkg.sv
// Shared widths, rounding constants and lane-packed typedefs for the 4x4 inverse transform.
package idct_pkg;

  localparam int unsigned CW = 14;       // signed coefficient width
  localparam int unsigned PW = 8;        // unsigned pixel width
  localparam int unsigned ZW = CW + 2;   // after vertical pass
  localparam int unsigned XW = CW + 4;   // after horizontal pass

  localparam int RND     = 8;
  localparam int SHR     = 4;
  localparam int PIX_MAX = 255;

  // Lane 0 occupies the low bits of each packed vector.
  typedef logic [3:0][CW-1:0] coef_lanes_t;
  typedef logic [3:0][ZW-1:0] z_lanes_t;
  typedef logic [3:0][XW-1:0] x_lanes_t;
  typedef logic [3:0][PW-1:0] pix_lanes_t;

endpackage

// File: rtl/idct4_1d.sv
// Combinational 4-point inverse integer transform; output lanes grow by two bits.
module idct4_1d #(
  parameter int unsigned IW = 14
) (
  input  logic [4*IW-1:0]     b,
  output logic [4*(IW+2)-1:0] a
);

  localparam int unsigned OW = IW + 2;

  logic signed [OW-1:0] e [4];
  logic signed [OW-1:0] r [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      e[i] = {{2{b[i*IW+IW-1]}}, b[i*IW +: IW]};
    end
    r[0] = e[0] + (e[1] <<< 1) + e[2];
    r[1] = e[0] - e[2] - (e[3] <<< 1);
    r[2] = e[0] - e[2] + (e[3] <<< 1);
    r[3] = e[0] - (e[1] <<< 1) + e[2];
    for (int i = 0; i < 4; i++) begin
      a[i*OW +: OW] = r[i];
    end
  end

endmodule

// File: rtl/idct4x4_stream.sv
// Streaming 2-D 4x4 inverse transform: columns in, vertical pass into a ping-pong
// transpose buffer, horizontal pass plus round/clamp into a registered pixel-row output.
module idct4x4_stream
  import idct_pkg::*;
(
  input  logic            ap_clk,
  input  logic            ap_rst_n,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [4*CW-1:0] s_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [4*PW-1:0] m_data,
  output logic            m_last
);

  logic [1:0]    ic_q;
  logic [1:0]    orow_q;
  logic          wb_q;
  logic          rb_q;
  logic [1:0]    full_q;
  logic [1:0]    full_d;
  logic [ZW-1:0] bank_q [2][4][4];

  z_lanes_t   zcol;
  z_lanes_t   zrow;
  x_lanes_t   xrow;
  pix_lanes_t pix;
  logic       accept;
  logic       load;

  logic signed [XW:0]     rsum;
  logic signed [XW-SHR:0] rsh;

  assign s_ready = ap_rst_n && !full_q[wb_q];
  assign accept  = s_valid && s_ready;
  assign load    = full_q[rb_q] && (!m_valid || m_ready);

  idct4_1d #(.IW(CW)) u_col (
    .b(s_data),
    .a(zcol)
  );

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      zrow[c] = bank_q[rb_q][orow_q][c];
    end
  end

  idct4_1d #(.IW(ZW)) u_row (
    .b(zrow),
    .a(xrow)
  );

  // Round half-up by 16 with an arithmetic shift, then saturate to the pixel range.
  always_comb begin
    pix  = '0;
    rsum = '0;
    rsh  = '0;
    for (int c = 0; c < 4; c++) begin
      rsum = {xrow[c][XW-1], xrow[c]} + (XW+1)'(RND);
      rsh  = rsum[XW:SHR];
      if (rsh[XW-SHR]) begin
        pix[c] = '0;
      end else if (rsh > (XW-SHR+1)'(PIX_MAX)) begin
        pix[c] = PW'(PIX_MAX);
      end else begin
        pix[c] = rsh[PW-1:0];
      end
    end
  end

  // Fill and drain always target different banks, so both updates can land together.
  always_comb begin
    full_d = full_q;
    if (accept && ic_q == 2'd3) full_d[wb_q] = 1'b1;
    if (load && orow_q == 2'd3) full_d[rb_q] = 1'b0;
  end

  always_ff @(posedge ap_clk) begin
    if (accept) begin
      for (int r = 0; r < 4; r++) begin
        bank_q[wb_q][r][ic_q] <= zcol[r];
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      ic_q    <= 2'd0;
      orow_q  <= 2'd0;
      wb_q    <= 1'b0;
      rb_q    <= 1'b0;
      full_q  <= 2'b00;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else begin
      full_q <= full_d;
      if (accept) begin
        ic_q <= ic_q + 2'd1;
        if (ic_q == 2'd3) wb_q <= ~wb_q;
      end
      if (load) begin
        m_valid <= 1'b1;
        m_data  <= pix;
        m_last  <= (orow_q == 2'd3);
        orow_q  <= orow_q + 2'd1;
        if (orow_q == 2'd3) rb_q <= ~rb_q;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule
